pcie_tx_resp_packer: RTL

Downstream stage of the PCIe command interface. It accepts 64-bit response words from the command-execution pipeline (register read-backs, status words) through a valid/ready port and buffers them in an internal FIFO. It packs the words into RIFFA TX transactions of up to `MAX_BURST` words and drives the full channel handshake: request, acknowledge, then stream with the receiver's read enable. This replaces single-word, unbuffered TX responses: several read responses now share one host transfer, with a timeout/flush path for partial bursts.

---
 rtl/pcie_tx_resp_packer.sv | 109 ++++++++++
 1 files changed

// File: rtl/pcie_tx_resp_packer.sv
// Buffers 64-bit response words in a FWFT FIFO and packs them into RIFFA TX
// transactions of up to MAX_BURST words, triggered by fill level, flush or idle timeout.
module pcie_tx_resp_packer #(
  parameter int C_PCI_DATA_WIDTH = 64,
  parameter int DEPTH            = 16,
  parameter int MAX_BURST        = 8,
  parameter int TIMEOUT          = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [C_PCI_DATA_WIDTH-1:0]   in_data,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          CHNL_TX_CLK,
  output logic                          CHNL_TX,
  input  logic                          CHNL_TX_ACK,
  output logic                          CHNL_TX_LAST,
  output logic [31:0]                   CHNL_TX_LEN,
  output logic [30:0]                   CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]   CHNL_TX_DATA,
  output logic                          CHNL_TX_DATA_VALID,
  input  logic                          CHNL_TX_DATA_REN,
  output logic                          busy,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic [1:0]                    dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C   = CW'(MAX_BURST);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, STREAM = 2'd2} state_t;

  // Handshakes: a word moves on any rising edge where its valid and ready are
  // both high (in_valid/in_ready upstream, DATA_VALID/DATA_REN toward the host);
  // valid, once raised, holds its data stable until accepted.
  state_t                        state, state_nxt;
  logic [C_PCI_DATA_WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 count;
  logic [BW-1:0]                 burst_words, sent, sent_inc;
  logic [TW-1:0]                 idle_timer;
  logic                          push, pop, start, last_pop;

  assign in_ready           = !rst && (count < DEPTH_C);
  assign push               = in_valid && in_ready;
  assign CHNL_TX_DATA_VALID = !rst && (state == STREAM) && (sent < burst_words);
  assign pop                = CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN;
  assign sent_inc           = sent + BW'(1);
  assign last_pop           = pop && (sent_inc == burst_words);
  assign start              = (state == IDLE) &&
                              ((count >= BURST_C) ||
                               ((count != '0) && (flush || (idle_timer == TIMER_MAX))));

  assign CHNL_TX_CLK  = clk;
  assign CHNL_TX      = !rst && (state != IDLE);
  assign busy         = !rst && (state != IDLE);
  assign CHNL_TX_LAST = 1'b1;
  assign CHNL_TX_OFF  = '0;
  assign CHNL_TX_LEN  = rst ? 32'd0 : (32'(burst_words) << 1);
  assign CHNL_TX_DATA = mem[rd_ptr];
  assign fifo_count   = count;
  assign dbg_state    = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (CHNL_TX_ACK) state_nxt = STREAM;
      STREAM:  if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      burst_words <= '0;
      sent        <= '0;
      idle_timer  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Burst size is frozen at request time; later pushes wait for the next burst.
      if (start) burst_words <= (count >= BURST_C) ? BW'(MAX_BURST) : BW'(count);
      if (state == REQ)   sent <= '0;
      else if (pop)       sent <= sent_inc;
      if ((state != IDLE) || start || push || (count == '0)) idle_timer <= '0;
      else if (idle_timer != TIMER_MAX)                      idle_timer <= idle_timer + TW'(1);
    end
  end
endmodule
